// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rxfilt_1.sv
// Receive-side input conditioner: resynchronises I, qualifies level changes over FILT_CNT cycles.
// Optional macro GF180MCU_FD_SC_MCU7T5V0__RXFILT_EDGE_EN enables the ZR/ZF edge-pulse flops.
module gf180mcu_fd_sc_mcu7t5v0__rxfilt_1 #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CNT    = 4,
    parameter logic INIT        = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic I,
    input  logic EN,
    output logic Z,
    output logic ZR,
    output logic ZF,
    output logic BUSY
);

    localparam int CNT_W = $clog2(FILT_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } state_t;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("rxfilt: SYNC_STAGES must be in 2..4");
        end
        if (FILT_CNT < 1 || FILT_CNT > 255) begin : g_bad_filt
            $error("rxfilt: FILT_CNT must be in 1..255");
        end
    endgenerate

    // Synchroniser chain; stage 0 samples the asynchronous input.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    assign sync_d[0] = I;
    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= {SYNC_STAGES{INIT}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_q, z_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            z_q     <= INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (EN && (s != z_q)) begin
                    if (FILT_CNT == 1) begin
                        z_d = s;
                    end else begin
                        state_d = QUAL;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            QUAL: begin
                // Any break in EN or in the difference discards all progress.
                if (!EN || (s == z_q)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    z_d     = s;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign Z    = z_q;
    assign BUSY = (state_q == QUAL);

`ifdef GF180MCU_FD_SC_MCU7T5V0__RXFILT_EDGE_EN
    // Pulses are registered alongside z_q so they coincide with the new Z value.
    logic zr_q, zf_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            zr_q <= 1'b0;
            zf_q <= 1'b0;
        end else begin
            zr_q <= ~z_q & z_d;
            zf_q <= z_q & ~z_d;
        end
    end

    assign ZR = zr_q;
    assign ZF = zf_q;
`else
    assign ZR = 1'b0;
    assign ZF = 1'b0;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rxfilt_1.sv
// Self-checking bench for the rxfilt cell: directed scenarios plus randomized run against a run-length model.
module tb_gf180mcu_fd_sc_mcu7t5v0__rxfilt_1;

    localparam int   SS  = 2;
    localparam int   FC  = 4;
    localparam logic INI = 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__RXFILT_EDGE_EN
    localparam int   EDGE = 1;
`else
    localparam int   EDGE = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_in = 1'b0;
    logic en = 1'b1;
    logic z, zr, zf, busy;

    int n_pass = 0;
    int n_total = 0;

    gf180mcu_fd_sc_mcu7t5v0__rxfilt_1 #(
        .SYNC_STAGES(SS),
        .FILT_CNT(FC),
        .INIT(INI)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .I(i_in),
        .EN(en),
        .Z(z),
        .ZR(zr),
        .ZF(zf),
        .BUSY(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    // Model: S is I delayed SS samples; Z flips once EN=1 and S!=Z held for FC consecutive edges.
    logic m_hist[$];
    int   m_run = 0;
    logic m_z = INI, m_zr = 1'b0, m_zf = 1'b0;
    bit   m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic s;
        if (rst) begin
            m_hist.delete();
            for (int k = 0; k < SS; k++) m_hist.push_back(INI);
            m_z = INI; m_run = 0; m_zr = 1'b0; m_zf = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            s = m_hist[SS-1];
            m_zr = 1'b0; m_zf = 1'b0;
            if (en && (s != m_z)) m_run++;
            else m_run = 0;
            if (m_run == FC) begin
                m_zr = s; m_zf = ~s; m_z = s; m_run = 0;
            end
            m_hist.push_front(i_in);
            void'(m_hist.pop_back());
        end
        #1;
        if (m_valid) begin
            check("cyc_z", int'(z), int'(m_z));
            check("cyc_busy", int'(busy), (m_run > 0) ? 1 : 0);
            check("cyc_zr", int'(zr), EDGE ? int'(m_zr) : 0);
            check("cyc_zf", int'(zf), EDGE ? int'(m_zf) : 0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; i_in = 1'b0; en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    // Waits for BUSY with a bounded budget; a timeout is a failed check.
    task automatic wait_busy(input string name);
        int k;
        for (k = 0; k < 20 && !busy; k++) tick();
        check(name, int'(busy), 1);
    endtask

    initial begin
        int first, cnt_b, cnt_z, cnt_r, cnt_f, zr_first, zr_after, remain;

        // Reset with I=1, EN=1
        rst = 1'b1; i_in = 1'b1; en = 1'b1;
        tick();
        check("rst_z", int'(z), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_zr_zf", int'(zr | zf), 0);
        tick();
        check("rst2_z", int'(z), 0);
        rst = 1'b0;
        first = -1; zr_first = -1; zr_after = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (first > 0 && zr_after < 0) zr_after = int'(zr);
            if (z && first < 0) begin first = k; zr_first = int'(zr); end
        end
        check("rst_release_latency", first, 6);
        check("rst_release_zr", zr_first, EDGE);
        check("rst_release_zr_next", zr_after, 0);

        // Glitch of 3 cycles
        do_reset();
        cnt_b = 0; cnt_z = 0; cnt_r = 0;
        i_in = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 3) i_in = 1'b0;
            tick();
            cnt_b += int'(busy); cnt_z += int'(z); cnt_r += int'(zr);
        end
        check("glitch_busy_cycles", cnt_b, 3);
        check("glitch_z_high", cnt_z, 0);
        check("glitch_zr", cnt_r, 0);

        // Minimum pulse of exactly FC cycles
        do_reset();
        cnt_z = 0; cnt_r = 0; cnt_f = 0;
        i_in = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 4) i_in = 1'b0;
            tick();
            cnt_z += int'(z); cnt_r += int'(zr); cnt_f += int'(zf);
        end
        check("minpulse_z_high", cnt_z, 4);
        check("minpulse_zr", cnt_r, EDGE);
        check("minpulse_zf", cnt_f, EDGE);

        // Enable freeze
        do_reset();
        i_in = 1'b1;
        wait_busy("freeze_busy_wait");
        tick();
        check("freeze_busy2", int'(busy), 1);
        en = 1'b0;
        tick();
        check("freeze_busy_drop", int'(busy), 0);
        cnt_z = 0;
        repeat (10) begin tick(); cnt_z += int'(z); end
        check("freeze_z_held", cnt_z, 0);
        en = 1'b1;
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (z && first < 0) first = k;
        end
        check("freeze_resume_latency", first, 4);

        // Reset in the middle of qualification
        do_reset();
        i_in = 1'b1;
        wait_busy("midrst_busy_wait");
        tick();
        rst = 1'b1;
        tick();
        check("midrst_z", int'(z), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_pulses", int'(zr | zf), 0);
        rst = 1'b0;
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (z && first < 0) first = k;
        end
        check("midrst_latency", first, 6);

        // Randomized run against the model
        remain = 0;
        for (int c = 0; c < 3000; c++) begin
            if (remain == 0) begin
                i_in = ~i_in;
                remain = $urandom_range(1, 7);
            end
            remain--;
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
